// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pc_gen_pkg: shared address width, PC increment and state encoding for fetch_pc_gen
package fetch_pc_gen_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {FPG_BOOT = 2'd0, FPG_RUN = 2'd1, FPG_HALT = 2'd2} fpg_state_e;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch request, prediction and redirect signals around the PC generator
interface fetch_pc_gen_if #(parameter int ADDR_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] next_pc, pc, predict_target_pc, fetch_pred_target;
  logic [ADDR_WIDTH-1:0] dec_redirect_pc, ex_redirect_pc, trap_redirect_pc;
  logic fetch_valid, fetch_ready, fetch_kill, predict_taken, fetch_pred_taken;
  logic dec_redirect, ex_redirect, trap_redirect, fetch_halt;
  modport master (
    output next_pc, pc, fetch_valid, fetch_kill, fetch_pred_taken, fetch_pred_target,
    input fetch_ready, predict_taken, predict_target_pc, dec_redirect, dec_redirect_pc,
    input ex_redirect, ex_redirect_pc, trap_redirect, trap_redirect_pc, fetch_halt
  );
  modport slave (
    input next_pc, pc, fetch_valid, fetch_kill, fetch_pred_taken, fetch_pred_target,
    output fetch_ready, predict_taken, predict_target_pc, dec_redirect, dec_redirect_pc,
    output ex_redirect, ex_redirect_pc, trap_redirect, trap_redirect_pc, fetch_halt
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage next-PC select and fetch request; define FETCH_PC_GEN_PERF_EN for perf counters
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
  input logic cpu_clk,
  input logic cpu_rst,
  fetch_pc_gen_if.master bus
`ifdef FETCH_PC_GEN_PERF_EN
  ,
  output logic [31:0] perf_ex_redirect_cnt,
  output logic [31:0] perf_pred_taken_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  fpg_state_e r_state;
  logic [ADDR_WIDTH-1:0] r_pc, w_next_pc;
  logic r_fetch_valid, w_adv, w_hard_redirect, w_redirect;
  assign w_adv = r_fetch_valid & bus.fetch_ready;
  assign w_hard_redirect = bus.trap_redirect | bus.ex_redirect;
  assign w_redirect = (r_state == FPG_RUN) & (w_hard_redirect | bus.dec_redirect);
  // Next fetch address; HALT only honours trap/EX redirects and otherwise re-reads pc
  always_comb
    w_next_pc = (cpu_rst || r_state == FPG_BOOT) ? BOOT_ADDR :
                bus.trap_redirect ? bus.trap_redirect_pc & ALIGN_MASK :
                bus.ex_redirect ? bus.ex_redirect_pc & ALIGN_MASK :
                (r_state == FPG_HALT) ? r_pc :
                bus.dec_redirect ? bus.dec_redirect_pc & ALIGN_MASK :
                (w_adv && bus.predict_taken) ? bus.predict_target_pc :
                w_adv ? r_pc + ADDR_WIDTH'(PC_INC) : r_pc;
  // Fetch FSM with registered pc and fetch_valid; a redirect beats a halt request
  always_ff @(posedge cpu_clk)
    if (cpu_rst) begin
      r_state <= FPG_BOOT;
      r_pc <= BOOT_ADDR;
      r_fetch_valid <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      case (r_state)
        FPG_BOOT: begin
          r_state <= FPG_RUN;
          r_fetch_valid <= 1'b1;
        end
        FPG_RUN: if (bus.fetch_halt && !w_redirect) begin
          r_state <= FPG_HALT;
          r_fetch_valid <= 1'b0;
        end
        FPG_HALT: if (!bus.fetch_halt || w_hard_redirect) begin
          r_state <= FPG_RUN;
          r_fetch_valid <= 1'b1;
        end
        default: begin
          r_state <= FPG_BOOT;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  assign bus.next_pc = w_next_pc;
  assign bus.pc = r_pc;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_kill = !cpu_rst & w_redirect & r_fetch_valid & !bus.fetch_ready;
  assign bus.fetch_pred_taken = !cpu_rst & bus.predict_taken & r_fetch_valid & !w_redirect;
  assign bus.fetch_pred_target = cpu_rst ? '0 : bus.predict_target_pc;
`ifdef FETCH_PC_GEN_PERF_EN
  // Saturating event counters
  always_ff @(posedge cpu_clk)
    if (cpu_rst) begin
      perf_ex_redirect_cnt <= '0;
      perf_pred_taken_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (bus.ex_redirect && !(&perf_ex_redirect_cnt)) perf_ex_redirect_cnt <= perf_ex_redirect_cnt + 32'd1;
      if (bus.fetch_pred_taken && !(&perf_pred_taken_cnt)) perf_pred_taken_cnt <= perf_pred_taken_cnt + 32'd1;
      if (r_fetch_valid && !bus.fetch_ready && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: table vectors, corner sequences and randomized model check for fetch_pc_gen
module tb_fetch_pc_gen;
  typedef struct packed {
    logic rst, rdy, ptk;
    logic [31:0] ptgt;
    logic dec;
    logic [31:0] decpc;
    logic ex;
    logic [31:0] expc;
    logic trap;
    logic [31:0] trappc;
    logic halt;
  } stim_t;
  typedef struct packed {
    stim_t s;
    logic [31:0] npc;
    logic kill, ptk;
    logic [31:0] pc;
    logic valid;
  } vec_t;
  typedef enum {M_BOOT, M_RUN, M_HALT} mode_e;
  localparam logic [31:0] BOOT = 32'h100;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  vec_t tv[$];
  mode_e m_mode = M_BOOT;
  logic [31:0] m_pc = BOOT;
  longint m_ex = 0, m_pt = 0, m_st = 0;
  fetch_pc_gen_if #(.ADDR_WIDTH(32)) bus ();
`ifdef FETCH_PC_GEN_PERF_EN
  logic [31:0] p_ex, p_pt, p_st;
`endif
  fetch_pc_gen #(.ADDR_WIDTH(32), .BOOT_ADDR(BOOT)) dut (
    .cpu_clk(clk),
    .cpu_rst(rst),
    .bus(bus)
`ifdef FETCH_PC_GEN_PERF_EN
    ,
    .perf_ex_redirect_cnt(p_ex),
    .perf_pred_taken_cnt(p_pt),
    .perf_stall_cnt(p_st)
`endif
  );
  always #5 clk = ~clk;
  function automatic stim_t st(logic r, logic rdy, logic ptk, logic [31:0] ptgt, logic dec, logic [31:0] decpc,
                               logic ex, logic [31:0] expc, logic trap, logic [31:0] trappc, logic halt);
    st = '{r, rdy, ptk, ptgt, dec, decpc, ex, expc, trap, trappc, halt};
  endfunction
  function automatic vec_t mk(stim_t s, logic [31:0] npc, logic kill, logic ptk, logic [31:0] pc, logic valid);
    mk = '{s, npc, kill, ptk, pc, valid};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input stim_t s);
    rst = s.rst;
    bus.fetch_ready = s.rdy;
    bus.predict_taken = s.ptk;
    bus.predict_target_pc = s.ptgt;
    bus.dec_redirect = s.dec;
    bus.dec_redirect_pc = s.decpc;
    bus.ex_redirect = s.ex;
    bus.ex_redirect_pc = s.expc;
    bus.trap_redirect = s.trap;
    bus.trap_redirect_pc = s.trappc;
    bus.fetch_halt = s.halt;
  endtask
  task automatic apply(input string nm, input vec_t v);
    drive(v.s);
    #3;
    chk({nm, ".next_pc"}, bus.next_pc, v.npc);
    chk({nm, ".kill"}, 32'(bus.fetch_kill), 32'(v.kill));
    chk({nm, ".pred_taken"}, 32'(bus.fetch_pred_taken), 32'(v.ptk));
    @(posedge clk);
    #1;
    chk({nm, ".pc"}, bus.pc, v.pc);
    chk({nm, ".valid"}, 32'(bus.fetch_valid), 32'(v.valid));
  endtask
  task automatic rand_cycle(input stim_t s);
    logic valid, adv, redir, e_kill, e_ptk;
    logic [31:0] npc;
    valid = (m_mode == M_RUN);
    adv = valid && s.rdy;
    redir = valid && (s.trap || s.ex || s.dec);
    if (s.rst || m_mode == M_BOOT) npc = BOOT;
    else if (s.trap) npc = {s.trappc[31:2], 2'b00};
    else if (s.ex) npc = {s.expc[31:2], 2'b00};
    else if (m_mode == M_HALT) npc = m_pc;
    else if (s.dec) npc = {s.decpc[31:2], 2'b00};
    else if (adv) npc = s.ptk ? s.ptgt : m_pc + 32'd4;
    else npc = m_pc;
    e_kill = !s.rst && redir && !s.rdy;
    e_ptk = !s.rst && s.ptk && valid && !redir;
    drive(s);
    #3;
    chk("rnd.next_pc", bus.next_pc, npc);
    chk("rnd.kill", 32'(bus.fetch_kill), 32'(e_kill));
    chk("rnd.pred_taken", 32'(bus.fetch_pred_taken), 32'(e_ptk));
    chk("rnd.pred_target", bus.fetch_pred_target, s.rst ? 32'd0 : s.ptgt);
    if (s.rst) begin
      m_ex = 0; m_pt = 0; m_st = 0;
    end else begin
      m_ex += longint'(s.ex);
      m_pt += longint'(e_ptk);
      m_st += longint'(valid && !s.rdy);
    end
    @(posedge clk);
    #1;
    if (s.rst) m_mode = M_BOOT;
    else if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (m_mode == M_RUN && s.halt && !redir) m_mode = M_HALT;
    else if (m_mode == M_HALT && (!s.halt || s.trap || s.ex)) m_mode = M_RUN;
    m_pc = npc;
    chk("rnd.pc", bus.pc, m_pc);
    chk("rnd.valid", 32'(bus.fetch_valid), 32'(m_mode == M_RUN));
  endtask
  initial begin
    logic halt_lvl;
    stim_t s;
    tv.push_back(mk(st(1,1,0,0,0,0,0,0,0,0,0), BOOT, 0, 0, BOOT, 0));
    tv.push_back(mk(st(1,1,0,0,0,0,0,0,0,0,0), BOOT, 0, 0, BOOT, 0));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), BOOT, 0, 0, BOOT, 1));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), 32'h104, 0, 0, 32'h104, 1));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), 32'h108, 0, 0, 32'h108, 1));
    tv.push_back(mk(st(0,1,1,32'h200,0,0,0,0,0,0,0), 32'h200, 0, 1, 32'h200, 1));
    tv.push_back(mk(st(0,1,1,32'h80,0,0,0,0,0,0,0), 32'h80, 0, 1, 32'h80, 1));
    tv.push_back(mk(st(0,1,0,0,1,32'h300,0,0,0,0,0), 32'h300, 0, 0, 32'h300, 1));
    for (int i = 0; i < 3; i++) tv.push_back(mk(st(0,0,0,0,0,0,0,0,0,0,0), 32'h300, 0, 0, 32'h300, 1));
    tv.push_back(mk(st(0,0,0,0,0,0,1,32'h1000,0,0,0), 32'h1000, 1, 0, 32'h1000, 1));
    tv.push_back(mk(st(0,1,1,32'h444,1,32'h50,1,32'h40,1,32'h8000_0000,0), 32'h8000_0000, 0, 0, 32'h8000_0000, 1));
    tv.push_back(mk(st(0,0,0,0,0,0,1,32'h43,0,0,0), 32'h40, 1, 0, 32'h40, 1));
    tv.push_back(mk(st(0,1,0,0,1,32'hFFFF_FFFC,0,0,0,0,0), 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), 32'h0, 0, 0, 32'h0, 1));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,1), 32'h4, 0, 0, 32'h4, 0));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,1), 32'h4, 0, 0, 32'h4, 0));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,1,32'h20,1), 32'h20, 0, 0, 32'h20, 1));
    tv.push_back(mk(st(0,1,0,0,0,0,1,32'h60,0,0,1), 32'h60, 0, 0, 32'h60, 1));
    tv.push_back(mk(st(0,0,0,0,0,0,0,0,0,0,1), 32'h60, 0, 0, 32'h60, 0));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), 32'h60, 0, 0, 32'h60, 1));
    tv.push_back(mk(st(0,1,0,0,1,32'h500,0,0,0,0,0), 32'h500, 0, 0, 32'h500, 1));
    tv.push_back(mk(st(1,1,0,0,0,0,1,32'h900,0,0,0), BOOT, 0, 0, BOOT, 0));
    tv.push_back(mk(st(0,1,0,0,0,0,0,0,0,0,0), BOOT, 0, 0, BOOT, 1));
    drive(st(1,1,0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    foreach (tv[i]) apply($sformatf("tv%0d", i), tv[i]);
`ifdef FETCH_PC_GEN_PERF_EN
    chk("perf_ex_after_rst", p_ex, 32'd0);
    chk("perf_pt_after_rst", p_pt, 32'd0);
    chk("perf_st_after_rst", p_st, 32'd0);
`endif
    apply("halt_pred", mk(st(0,1,1,32'h700,0,0,0,0,0,0,1), 32'h700, 0, 1, 32'h700, 0));
    apply("halt_dec_ign", mk(st(0,1,0,0,1,32'h900,0,0,0,0,1), 32'h700, 0, 0, 32'h700, 0));
    apply("halt_rst", mk(st(1,1,0,0,0,0,0,0,0,0,1), BOOT, 0, 0, BOOT, 0));
    apply("halt_boot", mk(st(0,1,0,0,0,0,0,0,0,0,0), BOOT, 0, 0, BOOT, 1));
    halt_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) halt_lvl = ~halt_lvl;
      s.rst = (i == 0) || ($urandom_range(63) == 0);
      s.rdy = $urandom_range(3) != 0;
      s.ptk = $urandom_range(2) == 0;
      s.ptgt = $urandom & 32'hFFFF_FFFC;
      s.dec = $urandom_range(7) == 0;
      s.decpc = $urandom;
      s.ex = $urandom_range(11) == 0;
      s.expc = $urandom;
      s.trap = $urandom_range(19) == 0;
      s.trappc = $urandom;
      s.halt = halt_lvl;
      rand_cycle(s);
    end
`ifdef FETCH_PC_GEN_PERF_EN
    chk("perf_ex_rnd", p_ex, 32'(m_ex));
    chk("perf_pt_rnd", p_pt, 32'(m_pt));
    chk("perf_st_rnd", p_st, 32'(m_st));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
